// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: decodes one stack-machine op per handshake into stack strobes,
// tracks live depth, rejects overflow/underflow/illegal ops and runs SWAP as a 3-cycle sequence.
module stack_ctrl #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_data,
   input  logic [WIDTH-1:0] stk_qtop,
   input  logic [WIDTH-1:0] stk_qnext,
   output logic             stk_load,
   output logic             stk_push,
   output logic             stk_pop,
   output logic [WIDTH-1:0] stk_d,
   output logic [3:0]       depth,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SW1  = 2'd1,
      S_SW2  = 2'd2
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_DUP  = 3'd5;
   localparam logic [2:0] OP_SWAP = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   localparam logic [1:0] ERR_OVF = 2'd1;
   localparam logic [1:0] ERR_UNF = 2'd2;
   localparam logic [1:0] ERR_ILL = 2'd3;

   localparam logic [3:0] DEPTH_FULL = 4'(DEPTH);

   state_t           r_state;
   logic [3:0]       r_depth;
   logic             r_done;
   logic             r_err;
   logic [1:0]       r_err_code;
   logic [WIDTH-1:0] r_pop_data;
   logic [WIDTH-1:0] r_tmp;
   logic [WIDTH-1:0] r_tmp2;

   logic             w_idle;
   logic             w_accept;
   logic             w_reject;
   logic             w_ok;
   logic [1:0]       w_code;
   logic             w_empty;
   logic             w_full;
   logic             w_lt2;
   logic             w_load;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_d;

   // Handshake: an op transfers on a rising edge where op_valid && op_ready;
   // op_ready is high only in IDLE and op_code/op_data are ignored in any other cycle.
   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = op_valid & w_idle & reset;
   assign w_ok     = w_accept & ~w_reject;

   assign w_empty  = (r_depth == 4'd0);
   assign w_full   = (r_depth == DEPTH_FULL);
   assign w_lt2    = (r_depth < 4'd2);

   always_comb begin
      w_reject = 1'b0;
      w_code   = 2'd0;
      case (op_code)
         OP_PUSH: begin
            if (w_full) begin
               w_reject = 1'b1;
               w_code   = ERR_OVF;
            end
         end
         OP_POP: begin
            if (w_empty) begin
               w_reject = 1'b1;
               w_code   = ERR_UNF;
            end
         end
         OP_ADD, OP_SUB, OP_SWAP: begin
            if (w_lt2) begin
               w_reject = 1'b1;
               w_code   = ERR_UNF;
            end
         end
         OP_DUP: begin
            if (w_full) begin
               w_reject = 1'b1;
               w_code   = ERR_OVF;
            end else if (w_empty) begin
               w_reject = 1'b1;
               w_code   = ERR_UNF;
            end
         end
         OP_ILL: begin
            w_reject = 1'b1;
            w_code   = ERR_ILL;
         end
         default: begin
            w_reject = 1'b0;
            w_code   = 2'd0;
         end
      endcase
   end

   // Strobes are combinational so the stack updates on the same edge as the depth counter.
   always_comb begin
      w_load = 1'b0;
      w_push = 1'b0;
      w_pop  = 1'b0;
      w_d    = '0;
      if (reset) begin
         case (r_state)
            S_IDLE: begin
               if (w_ok) begin
                  case (op_code)
                     OP_PUSH: begin
                        w_push = 1'b1;
                        w_load = 1'b1;
                        w_d    = op_data;
                     end
                     OP_POP: w_pop = 1'b1;
                     OP_ADD: begin
                        w_load = 1'b1;
                        w_pop  = 1'b1;
                        w_d    = stk_qnext + stk_qtop;
                     end
                     OP_SUB: begin
                        w_load = 1'b1;
                        w_pop  = 1'b1;
                        w_d    = stk_qnext - stk_qtop;
                     end
                     OP_DUP: begin
                        w_push = 1'b1;
                        w_load = 1'b1;
                        w_d    = stk_qtop;
                     end
                     OP_SWAP: w_pop = 1'b1;
                     default: w_load = 1'b0;
                  endcase
               end
            end
            S_SW1: begin
               w_load = 1'b1;
               w_d    = r_tmp;
            end
            S_SW2: begin
               w_push = 1'b1;
               w_load = 1'b1;
               w_d    = r_tmp2;
            end
            default: w_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_depth    <= 4'd0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
         r_pop_data <= '0;
         r_tmp      <= '0;
         r_tmp2     <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_reject) begin
                     r_err      <= 1'b1;
                     r_err_code <= w_code;
                  end else begin
                     r_err_code <= 2'd0;
                     case (op_code)
                        OP_PUSH, OP_DUP: begin
                           r_depth <= r_depth + 4'd1;
                           r_done  <= 1'b1;
                        end
                        OP_POP: begin
                           r_depth    <= r_depth - 4'd1;
                           r_pop_data <= stk_qtop;
                           r_done     <= 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                           r_depth <= r_depth - 4'd1;
                           r_done  <= 1'b1;
                        end
                        OP_SWAP: begin
                           r_tmp   <= stk_qtop;
                           r_state <= S_SW1;
                        end
                        default: r_done <= 1'b1;
                     endcase
                  end
               end
            end
            S_SW1: begin
               // The first entry was popped on the accept edge, so qtop now shows the old second entry.
               r_tmp2  <= stk_qtop;
               r_state <= S_SW2;
            end
            S_SW2: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign op_ready  = w_idle;
   assign stk_load  = w_load;
   assign stk_push  = w_push;
   assign stk_pop   = w_pop;
   assign stk_d     = w_d;
   assign depth     = r_depth;
   assign done      = r_done;
   assign err       = r_err;
   assign err_code  = r_err_code;
   assign pop_data  = r_pop_data;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with an 8-entry stack model driven by the controller's strobes;
// expected done/err responses go into a queue and a negedge monitor compares each pulse.
module tb_stack_ctrl;

   typedef struct packed {
      logic        err;
      logic [1:0]  code;
      logic [3:0]  depth;
      logic [15:0] top;
      logic [15:0] next;
      logic [15:0] pop;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [2:0]  op_code = 3'd0;
   logic [15:0] op_data = 16'd0;
   logic [15:0] stk_qtop;
   logic [15:0] stk_qnext;
   logic        stk_load;
   logic        stk_push;
   logic        stk_pop;
   logic [15:0] stk_d;
   logic [3:0]  depth;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] pop_data;
   logic [1:0]  dbg_state;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t m_e;

   logic [15:0] stk [0:7];
   logic [15:0] pv [0:9];

   stack_ctrl #(.WIDTH(16), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_data(op_data), .stk_qtop(stk_qtop), .stk_qnext(stk_qnext),
      .stk_load(stk_load), .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d),
      .depth(depth), .done(done), .err(err), .err_code(err_code),
      .pop_data(pop_data), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // stack model: index 0 is the top entry
   assign stk_qtop  = stk[0];
   assign stk_qnext = stk[1];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) stk[i] <= 16'd0;
      end else if (stk_push) begin
         for (int i = 7; i > 0; i--) stk[i] <= stk[i-1];
         stk[0] <= stk_d;
      end else if (stk_pop) begin
         for (int i = 0; i < 7; i++) stk[i] <= stk[i+1];
         stk[7] <= 16'd0;
         if (stk_load) stk[0] <= stk_d;
      end else if (stk_load) begin
         stk[0] <= stk_d;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver
   task automatic do_op(input logic [2:0] code, input logic [15:0] data, input logic e_err,
                        input logic [1:0] e_code, input logic [3:0] e_depth,
                        input logic [15:0] e_top, input logic [15:0] e_next, input logic [15:0] e_pop);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!op_ready) begin
         check("ready_timeout", {31'd0, op_ready}, 32'd1);
         return;
      end
      e.err = e_err; e.code = e_code; e.depth = e_depth;
      e.top = e_top; e.next = e_next; e.pop = e_pop;
      exp_q.push_back(e);
      op_valid = 1'b1;
      op_code  = code;
      op_data  = data;
      #1;
      if (e_err) check("reject_strobes", {29'd0, stk_push, stk_pop, stk_load}, 32'd0);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_code  = 3'($urandom_range(0, 7));
      op_data  = 16'($urandom_range(0, 65535));
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset && (done || err)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: done=%0b err=%0b with no expected op at %0t", done, err, $time);
         end else begin
            m_e = exp_q.pop_front();
            check("err_pulse",  {31'd0, err}, {31'd0, m_e.err});
            check("done_pulse", {31'd0, done}, {31'd0, ~m_e.err});
            check("err_code",   {30'd0, err_code}, {30'd0, m_e.code});
            check("depth",      {28'd0, depth}, {28'd0, m_e.depth});
            check("qtop",       {16'd0, stk_qtop}, {16'd0, m_e.top});
            check("qnext",      {16'd0, stk_qnext}, {16'd0, m_e.next});
            check("pop_data",   {16'd0, pop_data}, {16'd0, m_e.pop});
         end
      end
   end

   initial begin
      pv = '{16'h14, 16'h13, 16'h12, 16'h11, 16'h10, 16'h2, 16'h3, 16'h1, 16'h0, 16'h0};

      // reset with an op presented: nothing may move
      reset    = 1'b0;
      op_valid = 1'b1;
      op_code  = 3'd1;
      op_data  = 16'hBEEF;
      repeat (3) @(negedge clk);
      check("rst_depth",    {28'd0, depth}, 32'd0);
      check("rst_done_err", {30'd0, done, err}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_pop_data", {16'd0, pop_data}, 32'd0);
      check("rst_ready",    {31'd0, op_ready}, 32'd1);
      check("rst_strobes",  {29'd0, stk_push, stk_pop, stk_load}, 32'd0);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      reset    = 1'b1;

      // arithmetic with wrap
      do_op(3'd1, 16'h1234, 0, 0, 1, 16'h1234, 16'h0000, 16'h0);
      do_op(3'd1, 16'h0005, 0, 0, 2, 16'h0005, 16'h1234, 16'h0);
      do_op(3'd4, 16'h0000, 0, 0, 1, 16'h122F, 16'h0000, 16'h0);
      do_op(3'd1, 16'hFFFF, 0, 0, 2, 16'hFFFF, 16'h122F, 16'h0);
      do_op(3'd3, 16'h0000, 0, 0, 1, 16'h122E, 16'h0000, 16'h0);

      // rejects at shallow depth, illegal op
      do_op(3'd3, 16'h0000, 1, 2, 1, 16'h122E, 16'h0000, 16'h0);
      do_op(3'd7, 16'h0000, 1, 3, 1, 16'h122E, 16'h0000, 16'h0);
      do_op(3'd2, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h122E);
      do_op(3'd2, 16'h0000, 1, 2, 0, 16'h0000, 16'h0000, 16'h122E);
      do_op(3'd5, 16'h0000, 1, 2, 0, 16'h0000, 16'h0000, 16'h122E);

      // DUP
      do_op(3'd1, 16'h00AA, 0, 0, 1, 16'h00AA, 16'h0000, 16'h122E);
      do_op(3'd5, 16'h0000, 0, 0, 2, 16'h00AA, 16'h00AA, 16'h122E);
      do_op(3'd2, 16'h0000, 0, 0, 1, 16'h00AA, 16'h0000, 16'h00AA);
      do_op(3'd2, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h00AA);

      // SWAP on 3,2,1
      do_op(3'd1, 16'h0001, 0, 0, 1, 16'h0001, 16'h0000, 16'h00AA);
      do_op(3'd1, 16'h0002, 0, 0, 2, 16'h0002, 16'h0001, 16'h00AA);
      do_op(3'd1, 16'h0003, 0, 0, 3, 16'h0003, 16'h0002, 16'h00AA);
      do_op(3'd6, 16'h0000, 0, 0, 3, 16'h0002, 16'h0003, 16'h00AA);
      @(negedge clk);
      check("swap_ready_sw1", {31'd0, op_ready}, 32'd0);
      check("swap_state_sw1", {30'd0, dbg_state}, 32'd1);
      @(negedge clk);
      check("swap_ready_sw2", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      check("swap_ready_back", {31'd0, op_ready}, 32'd1);
      check("swap_third",      {16'd0, stk[2]}, 32'd1);
      do_op(3'd0, 16'h0000, 0, 0, 3, 16'h0002, 16'h0003, 16'h00AA);

      // fill to 8, then overflow
      do_op(3'd1, 16'h0010, 0, 0, 4, 16'h0010, 16'h0002, 16'h00AA);
      do_op(3'd1, 16'h0011, 0, 0, 5, 16'h0011, 16'h0010, 16'h00AA);
      do_op(3'd1, 16'h0012, 0, 0, 6, 16'h0012, 16'h0011, 16'h00AA);
      do_op(3'd1, 16'h0013, 0, 0, 7, 16'h0013, 16'h0012, 16'h00AA);
      do_op(3'd1, 16'h0014, 0, 0, 8, 16'h0014, 16'h0013, 16'h00AA);
      do_op(3'd1, 16'h0009, 1, 1, 8, 16'h0014, 16'h0013, 16'h00AA);
      do_op(3'd5, 16'h0000, 1, 1, 8, 16'h0014, 16'h0013, 16'h00AA);

      // drain, then underflow
      for (int i = 0; i < 8; i++)
         do_op(3'd2, 16'h0000, 0, 0, 4'(7 - i), pv[i+1], pv[i+2], pv[i]);
      do_op(3'd2, 16'h0000, 1, 2, 0, 16'h0000, 16'h0000, 16'h0001);

      // reset in the middle of a SWAP
      do_op(3'd1, 16'h0007, 0, 0, 1, 16'h0007, 16'h0000, 16'h0001);
      do_op(3'd1, 16'h0008, 0, 0, 2, 16'h0008, 16'h0007, 16'h0001);
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 3'd6;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("midswap_strobes", {29'd0, stk_push, stk_pop, stk_load}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midswap_ready", {31'd0, op_ready}, 32'd1);
      check("midswap_state", {30'd0, dbg_state}, 32'd0);
      check("midswap_depth", {28'd0, depth}, 32'd0);
      check("midswap_done",  {31'd0, done}, 32'd0);
      do_op(3'd1, 16'h0055, 0, 0, 1, 16'h0055, 16'h0000, 16'h0000);

      repeat (3) @(negedge clk);
      check("pending_responses", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
